alu_sched: RTL and testbench
============================

# alu_sched

Shared-ALU scheduler: accepts operation requests from `N_REQ` independent requesters, arbitrates round-robin, issues one operation per cycle into the registered 4-bit ALU datapath, and routes each result and carry back to its originator. Sits between the requester blocks and the ALU wrapper. Provides an enable/drain state machine so software can quiesce the ALU cleanly.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `ALU_LAT`, 2, cycles from `alu_a/b/op` valid to `alu_result/carry` valid (≥1)
- `clk` in 1, clock
- `rst_n` in 1, asynchronous, active-low reset
- `sched_en` in 1, 1 = grant requests; 0 = drain and idle
- `req_valid` in N_REQ, per-requester request
- `req_a` in 4*N_REQ, operand A, requester i at [4i+3:4i]
- `req_b` in 4*N_REQ, operand B, same packing
- `req_op` in 3*N_REQ, opcode, requester i at [3i+2:3i]
- `req_ready` out N_REQ, one-hot grant; transfer when valid & ready
- `alu_a` out 4, `alu_b` out 4, `alu_op` out 3, registered ALU operands
- `alu_result` in 4, `alu_carry` in 1, ALU outputs
- `rsp_valid` out N_REQ, one-hot single-cycle response strobe
- `rsp_result` out 4, `rsp_carry` out 1, response data, valid with `rsp_valid`
- `idle` out 1, 1 in IDLE state

## Operation
- Reset values: `req_ready`, `rsp_valid` = 0; `alu_a/b/op`, `rsp_result`, `rsp_carry` = 0; `idle` = 1; state IDLE; RR pointer = N_REQ-1 (requester 0 wins first); tag pipeline empty.
- FSM: IDLE → RUN when `sched_en`=1. RUN → DRAIN when `sched_en`=0. DRAIN → IDLE when tag pipeline empty (same cycle if already empty). DRAIN ignores `sched_en`; re-entry to RUN only via IDLE.
- Grant: combinational from `req_valid`, pointer and state; only in RUN. Search starts at pointer+1, wrapping modulo N_REQ; at most one bit of `req_ready` set. Pointer updates to granted index on each transfer; unchanged when no transfer.
- Requesters hold `req_*` stable while valid and not ready; withdrawing valid before grant is legal.
- Sole active requester is granted every cycle (full throughput).
- Issue: on transfer, granted operands/opcode registered onto `alu_*`; a valid bit plus requester index enter an `ALU_LAT`-deep tag shift register. No transfer: `alu_*` hold previous values, valid bit 0.
- Return: when tag pipeline output valid, `alu_result/carry` registered into `rsp_result/carry`, `rsp_valid[idx]` pulses 1 cycle. Responses have no backpressure; order equals issue order.
- Reset mid-operation: all in-flight tags discarded, no responses emitted.

## Timing
- Transfer in cycle t → `alu_*` valid t+1 → ALU output t+1+ALU_LAT → `rsp_valid` t+2+ALU_LAT. Default: 4-cycle request-to-response latency.
- Throughput: 1 op/cycle; up to ALU_LAT+1 ops in flight.
- `sched_en` falling in cycle t: no grant from t+1; `idle` rises one cycle after last `rsp_valid` pulse register loads.

## Configuration
- `ALU_SCHED_PRIO_EN` defined: requester 0 is fixed highest priority, granted whenever valid in RUN; remaining requesters round-robin among themselves; pointer unaffected by requester-0 grants.
- Undefined: pure round-robin across all requesters as above.

## Structure
- Package `alu_sched_pkg`: FSM state enum (IDLE, RUN, DRAIN), operand width 4, opcode width 3, default ALU_LAT.
- Sub-module `rr_arbiter` (parameterised N, req vector + pointer in, one-hot grant + index out); scheduler holds FSM, issue regs, tag pipeline, response regs.

## Test plan
- Single request, req0 a=4'hF b=4'h1 op=0 (bench ALU: op0=add) → `rsp_valid`=4'b0001 at t+4, result 4'h0, carry 1.
- All four valid continuously → grant order 0,1,2,3,0,1…; responses in same order, one per cycle.
- Req2 alone valid for 5 cycles → 5 consecutive grants, 5 back-to-back responses to req2.
- Two ops in flight, `sched_en`→0 → no further grants, both responses delivered, `idle`=1 after, FSM DRAIN→IDLE.
- `rst_n` asserted with 3 ops in flight → all outputs to reset values immediately; no `rsp_valid` after release.
- With `ALU_SCHED_PRIO_EN`: req0 and req2 both valid 3 cycles → req0 granted all 3; req2 granted on cycle 4 after req0 drops.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared types and widths for the alu_sched scheduler.
package alu_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int OPND_W      = 4;
  localparam int OP_W        = 3;
  localparam int ALU_LAT_DEF = 2;

endpackage

// File: rtl/alu_sched_rr_arbiter.sv
// Round-robin arbiter: the search starts one past ptr and wraps modulo N.
// Produces a one-hot grant plus its binary index.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_any
);
  localparam int IDX_W = $clog2(N);

  always_comb begin
    int j;
    logic [IDX_W-1:0] jj;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    j       = 0;
    jj      = '0;
    for (int i = 1; i <= N; i++) begin
      j  = (int'(ptr) + i) % N;
      jj = IDX_W'(j);
      if (!gnt_any && req[jj]) begin
        gnt[jj] = 1'b1;
        gnt_idx = jj;
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Shared-ALU scheduler: round-robin issue into a registered ALU, tag-routed responses.
// Define ALU_SCHED_PRIO_EN to give requester 0 fixed top priority over the round-robin.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ALU_LAT = ALU_LAT_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sched_en,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [OPND_W*N_REQ-1:0] req_a,
  input  logic [OPND_W*N_REQ-1:0] req_b,
  input  logic [OP_W*N_REQ-1:0]   req_op,
  output logic [N_REQ-1:0]        req_ready,
  output logic [OPND_W-1:0]       alu_a,
  output logic [OPND_W-1:0]       alu_b,
  output logic [OP_W-1:0]         alu_op,
  input  logic [OPND_W-1:0]       alu_result,
  input  logic                    alu_carry,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [OPND_W-1:0]       rsp_result,
  output logic                    rsp_carry,
  output logic                    idle
);
  localparam int IDX_W = $clog2(N_REQ);

  state_e                          state_q, state_d;
  logic                            idle_q, idle_d;
  logic [IDX_W-1:0]                ptr_q, ptr_d;
  logic [N_REQ-1:0]                arb_req, arb_gnt, gnt;
  logic [IDX_W-1:0]                arb_idx, gnt_idx;
  logic                            arb_any, run, xfer, pipe_empty;

  logic [OPND_W-1:0]               alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [OP_W-1:0]                 alu_op_q, alu_op_d;
  logic                            issue_vld_q, issue_vld_d;
  logic [IDX_W-1:0]                issue_idx_q, issue_idx_d;
  logic [ALU_LAT-1:0]              tag_vld_q, tag_vld_d;
  logic [ALU_LAT-1:0][IDX_W-1:0]   tag_idx_q, tag_idx_d;
  logic [N_REQ-1:0]                rsp_valid_q, rsp_valid_d;
  logic [OPND_W-1:0]               rsp_result_q, rsp_result_d;
  logic                            rsp_carry_q, rsp_carry_d;

  assign run = (state_q == ST_RUN);

`ifdef ALU_SCHED_PRIO_EN
  assign arb_req = run ? (req_valid & ~N_REQ'(1)) : '0;
`else
  assign arb_req = run ? req_valid : '0;
`endif

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req     (arb_req),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  always_comb begin
    gnt     = arb_gnt;
    gnt_idx = arb_idx;
    ptr_d   = arb_any ? arb_idx : ptr_q;
`ifdef ALU_SCHED_PRIO_EN
    // Requester 0 overrides the round-robin and leaves the pointer alone.
    if (run && req_valid[0]) begin
      gnt     = N_REQ'(1);
      gnt_idx = '0;
      ptr_d   = ptr_q;
    end
`endif
  end

  assign xfer       = |gnt;
  assign pipe_empty = !issue_vld_q && (tag_vld_q == '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (sched_en)   state_d = ST_RUN;
      ST_RUN:   if (!sched_en)  state_d = ST_DRAIN;
      ST_DRAIN: if (pipe_empty) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
    idle_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idle_q  <= 1'b1;
      ptr_q   <= IDX_W'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
      ptr_q   <= ptr_d;
    end
  end

  // Issue stage: operands onto the ALU, tag into the shift register.
  always_comb begin
    alu_a_d     = xfer ? req_a[gnt_idx*OPND_W +: OPND_W] : alu_a_q;
    alu_b_d     = xfer ? req_b[gnt_idx*OPND_W +: OPND_W] : alu_b_q;
    alu_op_d    = xfer ? req_op[gnt_idx*OP_W +: OP_W]    : alu_op_q;
    issue_vld_d = xfer;
    issue_idx_d = gnt_idx;

    tag_vld_d[0] = issue_vld_q;
    tag_idx_d[0] = issue_idx_q;
    for (int i = 1; i < ALU_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_idx_d[i] = tag_idx_q[i-1];
    end

    // Return stage: tag output lines up with the ALU result.
    rsp_valid_d  = tag_vld_q[ALU_LAT-1] ? (N_REQ'(1) << tag_idx_q[ALU_LAT-1]) : '0;
    rsp_result_d = tag_vld_q[ALU_LAT-1] ? alu_result : rsp_result_q;
    rsp_carry_d  = tag_vld_q[ALU_LAT-1] ? alu_carry  : rsp_carry_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      issue_vld_q  <= 1'b0;
      issue_idx_q  <= '0;
      tag_vld_q    <= '0;
      tag_idx_q    <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
    end else begin
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      issue_vld_q  <= issue_vld_d;
      issue_idx_q  <= issue_idx_d;
      tag_vld_q    <= tag_vld_d;
      tag_idx_q    <= tag_idx_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
    end
  end

  assign req_ready  = gnt;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_carry  = rsp_carry_q;
  assign idle       = idle_q;

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched with a 2-cycle registered ALU model
// (op0 add, op1 sub/borrow, op2 and, op3 or, op4 xor, else pass A).
module tb_alu_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sched_en = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic [11:0] req_op = '0;
  logic [3:0]  req_ready;
  logic [3:0]  alu_a, alu_b;
  logic [2:0]  alu_op;
  logic [3:0]  alu_result;
  logic        alu_carry;
  logic [3:0]  rsp_valid;
  logic [3:0]  rsp_result;
  logic        rsp_carry;
  logic        idle;

  int n_cmp = 0;
  int n_err = 0;

  logic [4:0] alu_s1 = '0;
  logic [4:0] alu_s2 = '0;

  // Expected results for the shared 4-requester operand table.
  logic [3:0] exp_r  [4] = '{4'h3, 4'hE, 4'h8, 4'h6};
  logic       exp_cy [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  alu_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sched_en   (sched_en),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .req_ready  (req_ready),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                       input logic [2:0] op);
    case (op)
      3'd0:    alu_f = {1'b0, a} + {1'b0, b};
      3'd1:    alu_f = {1'b0, a} - {1'b0, b};
      3'd2:    alu_f = {1'b0, a & b};
      3'd3:    alu_f = {1'b0, a | b};
      3'd4:    alu_f = {1'b0, a ^ b};
      default: alu_f = {1'b0, a};
    endcase
  endfunction

  always @(posedge clk) begin
    alu_s1 <= alu_f(alu_a, alu_b, alu_op);
    alu_s2 <= alu_s1;
  end
  assign alu_result = alu_s2[3:0];
  assign alu_carry  = alu_s2[4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    sched_en  = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic start_run();
    apply_reset();
    sched_en = 1'b1;
    step();
  endtask

  task automatic set_table_ops();
    req_a  = {4'hC, 4'hC, 4'h5, 4'h1};
    req_b  = {4'hA, 4'hA, 4'h7, 4'h2};
    req_op = {3'd4, 3'd2, 3'd1, 3'd0};
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    sched_en  = 1'b1;
    req_valid = 4'hF;
    set_table_ops();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL reset_ready: got %b want %b", req_ready, 4'b0); end
    n_cmp++; if (rsp_valid !== 4'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want %b", rsp_valid, 4'b0); end
    n_cmp++; if ({alu_a, alu_b, alu_op} !== 11'b0) begin n_err++; $display("FAIL reset_alu: got %h/%h/%h want 0", alu_a, alu_b, alu_op); end
    n_cmp++; if ({rsp_result, rsp_carry} !== 5'b0) begin n_err++; $display("FAIL reset_rsp_data: got %h/%b want 0", rsp_result, rsp_carry); end
    n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL reset_idle: got %b want 1", idle); end
    req_valid = '0;
  endtask

  task automatic test_single();
    start_run();
    req_a = 16'h000F; req_b = 16'h0001; req_op = 12'h000;
    req_valid = 4'b0001;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) begin
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_grant: got %b want 0001", req_ready); end
      end
      if (c == 1) begin
        n_cmp++; if ({alu_a, alu_b, alu_op} !== {4'hF, 4'h1, 3'd0}) begin n_err++; $display("FAIL single_issue: got %h/%h/%h want f/1/0", alu_a, alu_b, alu_op); end
      end
      if (c == 4) begin
        n_cmp++; if ({rsp_valid, rsp_result, rsp_carry} !== {4'b0001, 4'h0, 1'b1}) begin n_err++; $display("FAIL single_rsp: got %b/%h/%b want 0001/0/1", rsp_valid, rsp_result, rsp_carry); end
      end else begin
        n_cmp++; if (rsp_valid !== 4'b0) begin n_err++; $display("FAIL single_no_rsp c%0d: got %b want 0000", c, rsp_valid); end
      end
      step();
      req_valid = '0;
    end
  endtask

  task automatic test_all_four();
    logic [3:0] exp_rdy, exp_rsp;
    start_run();
    set_table_ops();
    req_valid = 4'hF;
    for (int c = 0; c < 13; c++) begin
      if (c == 8) req_valid = '0;
      @(negedge clk);
      exp_rdy = (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000;
      exp_rsp = (c >= 4 && c < 12) ? (4'b0001 << ((c - 4) % 4)) : 4'b0000;
      n_cmp++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL rr_grant c%0d: got %b want %b", c, req_ready, exp_rdy); end
      n_cmp++; if (rsp_valid !== exp_rsp) begin n_err++; $display("FAIL rr_rsp_valid c%0d: got %b want %b", c, rsp_valid, exp_rsp); end
      if (c >= 4 && c < 12) begin
        n_cmp++;
        if ({rsp_result, rsp_carry} !== {exp_r[(c-4)%4], exp_cy[(c-4)%4]}) begin
          n_err++;
          $display("FAIL rr_rsp_data c%0d: got %h/%b want %h/%b", c, rsp_result, rsp_carry, exp_r[(c-4)%4], exp_cy[(c-4)%4]);
        end
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_rdy, exp_rsp;
    start_run();
    req_a = 16'h0900; req_b = 16'h0800; req_op = 12'h000;
    req_valid = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      if (c == 5) req_valid = '0;
      @(negedge clk);
      exp_rdy = (c < 5) ? 4'b0100 : 4'b0000;
      exp_rsp = (c >= 4 && c < 9) ? 4'b0100 : 4'b0000;
      n_cmp++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL b2b_grant c%0d: got %b want %b", c, req_ready, exp_rdy); end
      n_cmp++; if (rsp_valid !== exp_rsp) begin n_err++; $display("FAIL b2b_rsp_valid c%0d: got %b want %b", c, rsp_valid, exp_rsp); end
      if (c >= 4 && c < 9) begin
        n_cmp++; if ({rsp_result, rsp_carry} !== {4'h1, 1'b1}) begin n_err++; $display("FAIL b2b_rsp_data c%0d: got %h/%b want 1/1", c, rsp_result, rsp_carry); end
      end
      step();
    end
  endtask

  task automatic test_drain();
    logic [3:0] exp_rdy, exp_rsp;
    logic [4:0] exp_d;
    logic       exp_idle;
    start_run();
    req_a = 16'h0042; req_b = 16'h0043; req_op = {3'd0, 3'd0, 3'd3, 3'd0};
    for (int c = 0; c < 8; c++) begin
      case (c)
        0:       begin req_valid = 4'b0001; sched_en = 1'b1; end
        1:       begin req_valid = 4'b0010; sched_en = 1'b0; end
        default: begin req_valid = 4'b0011; sched_en = 1'b0; end
      endcase
      @(negedge clk);
      exp_rdy  = (c == 0) ? 4'b0001 : (c == 1) ? 4'b0010 : 4'b0000;
      exp_rsp  = (c == 4) ? 4'b0001 : (c == 5) ? 4'b0010 : 4'b0000;
      exp_d    = (c == 4) ? {4'h5, 1'b0} : {4'h4, 1'b0};
      exp_idle = (c >= 6);
      n_cmp++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL drain_grant c%0d: got %b want %b", c, req_ready, exp_rdy); end
      n_cmp++; if (rsp_valid !== exp_rsp) begin n_err++; $display("FAIL drain_rsp_valid c%0d: got %b want %b", c, rsp_valid, exp_rsp); end
      n_cmp++; if (idle !== exp_idle) begin n_err++; $display("FAIL drain_idle c%0d: got %b want %b", c, idle, exp_idle); end
      if (c == 4 || c == 5) begin
        n_cmp++; if ({rsp_result, rsp_carry} !== exp_d) begin n_err++; $display("FAIL drain_rsp_data c%0d: got %h/%b want %h/%b", c, rsp_result, rsp_carry, exp_d[4:1], exp_d[0]); end
      end
      step();
    end
    req_valid = '0;
  endtask

  task automatic test_reset_inflight();
    start_run();
    set_table_ops();
    req_valid = 4'hF;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({alu_a, alu_b, alu_op} !== 11'b0) begin n_err++; $display("FAIL midrst_alu: got %h/%h/%h want 0", alu_a, alu_b, alu_op); end
    n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL midrst_idle: got %b want 1", idle); end
    n_cmp++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL midrst_ready: got %b want 0000", req_ready); end
    n_cmp++; if (rsp_valid !== 4'b0) begin n_err++; $display("FAIL midrst_rsp: got %b want 0000", rsp_valid); end
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 4'b0) begin n_err++; $display("FAIL midrst_stale_rsp c%0d: got %b want 0000", c, rsp_valid); end
      step();
    end
  endtask

  task automatic test_prio();
    logic [3:0] exp_rdy [4];
`ifdef ALU_SCHED_PRIO_EN
    exp_rdy = '{4'b0001, 4'b0001, 4'b0001, 4'b0100};
`else
    exp_rdy = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
`endif
    start_run();
    set_table_ops();
    for (int c = 0; c < 4; c++) begin
      req_valid = (c < 3) ? 4'b0101 : 4'b0100;
      @(negedge clk);
      n_cmp++; if (req_ready !== exp_rdy[c]) begin n_err++; $display("FAIL prio_grant c%0d: got %b want %b", c, req_ready, exp_rdy[c]); end
      step();
    end
    req_valid = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_back_to_back();
    test_drain();
    test_reset_inflight();
    test_prio();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
